// File: rtl/mdu_pkg.sv
// Shared opcode/state definitions for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: {HI,LO} result for the requested op.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] qs_u;
    logic [31:0] rs_u;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    assign div_zero_o = (rt_i == '0);
    // Divisor forced to 1 on zero so the datapath never produces X; result is discarded.
    assign divisor    = div_zero_o ? 32'd1 : rt_i;

    // Signed divide via magnitudes; 0x80000000 negates to itself and still works.
    assign a_abs = rs_i[31] ? -rs_i : rs_i;
    assign b_abs = divisor[31] ? -divisor : divisor;
    assign qs_u  = a_abs / b_abs;
    assign rs_u  = a_abs % b_abs;
    assign q_s   = (rs_i[31] ^ divisor[31]) ? -qs_u : qs_u;
    assign r_s   = rs_i[31] ? -rs_u : rs_u;

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_MULT:  result_o = prod_s;
            OP_MULTU: result_o = prod_u;
            OP_DIV:   result_o = {r_s, q_s};
            OP_DIVU:  result_o = {rs_i % divisor, rs_i / divisor};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency sequencing and busy/start.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
        $error("mdu_sequencer: MULT_CYCLES and DIV_CYCLES must both be >= 1");
    end

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      arith_result;
    logic             arith_div_zero;
    logic             go;

    mdu_arith u_arith (
        .op_i       (op),
        .rs_i       (rs_val),
        .rt_i       (rt_val),
        .result_o   (arith_result),
        .div_zero_o (arith_div_zero)
    );

    assign busy  = (state_q == RUN);
    assign go    = en & ~flush & ~busy;
    assign start = go & is_muldiv(op);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    // Divide-by-zero pends the current HI/LO so the commit leaves them unchanged.
                    if ((op == OP_DIV || op == OP_DIVU) && arith_div_zero) begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end else begin
                        pend_hi_d = arith_result[63:32];
                        pend_lo_d = arith_result[31:0];
                    end
                    cnt_d = (op == OP_MULT || op == OP_MULTU) ? CNT_W'(MULT_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
                end else if (go && op == OP_MTHI) begin
                    hi_d = rs_val;
                end else if (go && op == OP_MTLO) begin
                    lo_d = rs_val;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (op == OP_MFHI) begin
            rd_data = hi_q;
        end else if (op == OP_MFLO) begin
            rd_data = lo_q;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          run_len = 0;
    bit          busy_prev = 1'b0;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .start   (start),
        .busy    (busy),
        .rd_data (rd_data),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural behaviour from plain integer arithmetic.
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] chi, input logic [31:0] clo,
                                      output logic [31:0] nhi, output logic [31:0] nlo,
                                      output int cyc);
        longint          p;
        longint unsigned pu;
        longint          q;
        longint          r;
        nhi = chi;
        nlo = clo;
        cyc = 0;
        case (o)
            4'd1: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                nhi = 32'(p >>> 32);
                nlo = 32'(p);
                cyc = MC;
            end
            4'd2: begin
                pu  = longint'(a) * longint'(b);
                nhi = 32'(pu >> 32);
                nlo = 32'(pu);
                cyc = MC;
            end
            4'd3: begin
                cyc = DC;
                if (b != 0) begin
                    q   = longint'($signed(a)) / longint'($signed(b));
                    r   = longint'($signed(a)) % longint'($signed(b));
                    nlo = 32'(q);
                    nhi = 32'(r);
                end
            end
            4'd4: begin
                cyc = DC;
                if (b != 0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            end
            4'd5: nhi = a;
            4'd6: nlo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a falling edge with busy low; returns at a falling edge with busy low.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit fl);
        logic [31:0] nhi, nlo;
        int          cyc;
        bit          acc;
        bit          done;
        acc    = !fl && (o >= 4'd1) && (o <= 4'd4);
        en     = 1'b1;
        flush  = fl;
        op     = o;
        rs_val = a;
        rt_val = b;
        #2;
        chk("start", 32'(start), 32'(acc));
        if (o == 4'd7)      chk("rd_mfhi", rd_data, m_hi);
        else if (o == 4'd8) chk("rd_mflo", rd_data, m_lo);
        else                chk("rd_other", rd_data, 32'd0);
        ref_model(o, a, b, m_hi, m_lo, nhi, nlo, cyc);
        @(posedge clk);
        #1;
        en    = 1'b0;
        flush = 1'b0;
        op    = 4'd0;
        if (!fl) begin
            if (cyc > 0) sb.push_back('{nhi, nlo, cyc});
            m_hi = nhi;
            m_lo = nlo;
        end
        @(negedge clk);
        chk("busy_rise", 32'(busy), 32'(acc));
        done = !busy;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        if (!done) chk("busy_timeout", 32'(busy), 32'd0);
        chk("hi_out", hi_out, m_hi);
        chk("lo_out", lo_out, m_lo);
    endtask

    // Monitor: each completed busy period retires one scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            busy_prev = 1'b0;
        end else begin
            if (en && busy) begin
                errors++;
                $display("FAIL en_while_busy: got en=1 busy=1 required busy=0");
            end
            if (busy) run_len++;
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_commit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("busy_len", 32'(run_len), 32'(e.cycles));
                    chk("commit_hi", hi_out, e.hi);
                    chk("commit_lo", lo_out, e.lo);
                end
                run_len = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        flush  = 1'b0;
        op     = 4'd7;
        rs_val = '0;
        rt_val = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        op = 4'd0;
        #2 reset = 1'b0;
        @(negedge clk);

        do_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_hi_const", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo_out, 32'hFFFF_FFF1);
        do_op(4'd8, 32'd0, 32'd0, 1'b0);
        do_op(4'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_lo_const", lo_out, 32'd3);
        chk("divu_hi_const", hi_out, 32'd1);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi_out, 32'hFFFF_FFFF);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", lo_out, 32'h8000_0000);
        chk("div_ovf_hi", hi_out, 32'd0);
        do_op(4'd5, 32'h11, 32'd0, 1'b0);
        do_op(4'd6, 32'h22, 32'd0, 1'b0);
        do_op(4'd3, 32'h1234_5678, 32'd0, 1'b0);
        chk("div0_hi", hi_out, 32'h11);
        chk("div0_lo", lo_out, 32'h22);
        do_op(4'd1, 32'd3, 32'd4, 1'b1);
        do_op(4'd5, 32'h99, 32'd0, 1'b1);
        chk("flush_hi", hi_out, 32'h11);
        do_op(4'd7, 32'd0, 32'd0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(0, 15));
            a = rnd_val();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_val();
            do_op(o, a, b, $urandom_range(0, 7) == 0);
        end

        // Reset in the third busy cycle of a multiply.
        do_op(4'd5, 32'hABCD_0001, 32'd0, 1'b0);
        do_op(4'd6, 32'h0000_BEEF, 32'd0, 1'b0);
        en     = 1'b1;
        op     = 4'd1;
        rs_val = 32'd7;
        rt_val = 32'd9;
        #2;
        chk("mid_start", 32'(start), 32'd1);
        @(posedge clk);
        #1;
        en = 1'b0;
        op = 4'd0;
        repeat (3) @(negedge clk);
        chk("mid_busy3", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi", hi_out, 32'd0);
        chk("mid_rst_lo", lo_out, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_hi", hi_out, 32'd0);
        chk("post_rst_lo", lo_out, 32'd0);
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("post_rst_mult_hi", hi_out, 32'hFFFF_FFFE);
        chk("post_rst_mult_lo", lo_out, 32'h0000_0001);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multiply/divide unit with its own sequencing controller, located in the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations and holds the HI and LO registers. It produces the `start` and `busy` signals that the hazard unit uses to stall HI/LO consumers in D, and counts a fixed latency for each multiply or divide before it commits the result.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  E-stage instruction valid.
- `flush`  in  1  E-stage instruction cancelled (exception/interrupt); suppresses every side effect this cycle.
- `op`  in  4  operation code from `mdu_pkg`.
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `start`  out  1  combinational; a mult/div is accepted this cycle.
- `busy`  out  1  registered; an operation is in flight.
- `rd_data`  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- `hi_out`, `lo_out`  out  32 each  current architectural HI and LO.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9–15 behave as NONE.
- `go = en & !flush & !busy`.
- `start = go & op∈{MULT,MULTU,DIV,DIVU}`.
- FSM has two states:
  - IDLE → RUN on `start`.
    - Latch the 64-bit result into `pend_hi`/`pend_lo`.
    - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - RUN: `cnt` decrements every cycle.
    - When `cnt==1`, write `pend` into HI/LO, clear `cnt`, and return to IDLE.
- `busy` is 1 exactly in the RUN state.
- MULT: signed 32×32 → 64; HI = [63:32], LO = [31:0].
- MULTU: the same multiply, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: still runs the full DIV_CYCLES, and HI/LO are left unchanged at commit.
- MTHI/MTLO when `go`: write `rs_val` into HI/LO at the clock edge. No busy period.
- Any op arriving while `busy` is ignored. The hazard unit guarantees this does not happen; the bench asserts it.
- `flush` during RUN does not cancel the in-flight operation, because that instruction has already retired past E.
- Reset clears:
  - HI and LO to 0.
  - `pend` to 0 and `cnt` to 0.
  - The FSM to IDLE, so `busy`=0.
- A reset asserted mid-operation drops the pending result.

## Timing
- Cycle T: `start`=1. The op is latched at the T edge.
- Cycles T+1 … T+N: `busy`=1, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO are updated at the end of T+N. At T+N+1, `busy`=0 and `hi_out`/`lo_out`/`rd_data` show the new values.
- A back-to-back mult/div may issue at T+N+1.
- MTHI/MTLO issued at cycle T are visible on `hi_out`/`lo_out` at T+1.
- MFHI/MFLO `rd_data` is combinational from the registers and never sees an uncommitted result.
- Reset outputs: `start`=0 (since `busy`=0 and `en` is gated by the pipeline), `busy`=0, `rd_data`=0, `hi_out`=0, `lo_out`=0.
- Counter width is `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`. Both parameters must be ≥1, checked by an elaboration assertion.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op_e` enum (4 bits);
  - the `mdu_state_e` {IDLE, RUN};
  - the helper function `is_muldiv(op)`.
- One sub-module, `mdu_arith`: purely combinational.
  - Inputs: op, rs, rt. Outputs: 64-bit result plus a `div_zero` flag.
  - It contains the signed/unsigned multiply, the signed/unsigned divide, and the remainder sign fix-up.
- `mdu_sequencer` contains the FSM, the counter, the pend registers, HI/LO, and the output muxing.

## Test plan
- mult rs=0xFFFFFFFD (−3), rt=5:
  - `start` is high for one cycle, then `busy` is high for 5 cycles.
  - Afterwards HI=0xFFFFFFFF and LO=0xFFFFFFF1.
  - MFLO in the first non-busy cycle returns 0xFFFFFFF1.
- divu 7/2: `busy` for 10 cycles, then LO=3, HI=1.
- div 0xFFFFFFF9/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- div by zero with HI=0x11, LO=0x22 preloaded via MTHI/MTLO:
  - `busy` for 10 cycles.
  - HI=0x11 and LO=0x22 unchanged afterwards.
- mult with `flush`=1: `start`=0 and `busy` never rises, HI/LO are unchanged, and a MTHI with `flush`=1 also has no effect.
- Reset asserted in the 3rd busy cycle of a mult:
  - `busy`=0 immediately (asynchronous), HI=LO=0.
  - After release no commit occurs, and a new mult is accepted on the next cycle.
